// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Frame bit 4*c+r set means key (column c, row r) is pressed.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;

    typedef logic [ROWS*COLS-1:0] frame_t;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic popcount_ge2(frame_t f);
        return (f & (f - frame_t'(1))) != '0;
    endfunction

    // Bit index 4*c+r is already the key code {c[1:0], r[1:0]}.
    function automatic logic [KEY_W-1:0] encode_onehot(frame_t f);
        logic [KEY_W-1:0] code;
        code = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            if (f[i]) code = KEY_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
// RESET_VAL lets active-low lines come out of reset in their idle state.
module sync2 #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, builds a
// pressed map per frame, debounces whole frames and reports clean key events.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 17,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_down,
    output logic             multi
);

    localparam int               STB_W   = $clog2(DEBOUNCE + 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE);

    logic [ROWS-1:0]     rowSync;
    logic [SCAN_DIV-1:0] cnt_q, cnt_d;
    logic [1:0]          ci_q, ci_d;
    frame_t              frame_q, frame_d;
    frame_t              prev_q, prev_d;
    frame_t              committed_q, committed_d;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                keyValid_q, keyValid_d;
    logic                keyDown_q, keyDown_d;
    logic                multi_q, multi_d;
    logic                tick;
    logic                frameDone;
    logic                commit;
    frame_t              scanFrame;

    sync2 #(
        .WIDTH     (ROWS),
        .RESET_VAL ({ROWS{1'b1}})
    ) u_rowSync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (row),
        .q_o    (rowSync)
    );

    always_comb begin
        cnt_d       = cnt_q + SCAN_DIV'(1);
        tick        = &cnt_q;
        ci_d        = ci_q;
        frame_d     = frame_q;
        prev_d      = prev_q;
        stable_d    = stable_q;
        committed_d = committed_q;
        key_d       = key_q;
        keyValid_d  = 1'b0;
        keyDown_d   = keyDown_q;
        multi_d     = multi_q;
        frameDone   = 1'b0;
        commit      = 1'b0;

        // The frame as it will look once the current column's sample lands.
        scanFrame = frame_q;
        scanFrame[{ci_q, 2'b00} +: ROWS] = ~rowSync;

        if (tick) begin
            frame_d   = scanFrame;
            ci_d      = ci_q + 2'd1;
            frameDone = (ci_q == 2'd3);
        end

        if (frameDone) begin
            if (scanFrame != prev_q) begin
                prev_d   = scanFrame;
                stable_d = STB_W'(1);
                commit   = (DEBOUNCE == 1);
            end else if (stable_q != STB_MAX) begin
                stable_d = stable_q + STB_W'(1);
                commit   = (stable_d == STB_MAX);
            end
        end

        // Only an idle-to-single-key transition counts as a press event.
        if (commit) begin
            committed_d = scanFrame;
            keyDown_d   = |scanFrame;
            multi_d     = popcount_ge2(scanFrame);
            if (committed_q == '0 && scanFrame != '0 && !popcount_ge2(scanFrame)) begin
                key_d      = encode_onehot(scanFrame);
                keyValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            ci_q        <= '0;
            frame_q     <= '0;
            prev_q      <= '0;
            committed_q <= '0;
            stable_q    <= '0;
            key_q       <= '0;
            keyValid_q  <= 1'b0;
            keyDown_q   <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ci_q        <= ci_d;
            frame_q     <= frame_d;
            prev_q      <= prev_d;
            committed_q <= committed_d;
            stable_q    <= stable_d;
            key_q       <= key_d;
            keyValid_q  <= keyValid_d;
            keyDown_q   <= keyDown_d;
            multi_q     <= multi_d;
        end
    end

    assign col       = ~(COLS'(1) << ci_q);
    assign key       = key_q;
    assign key_valid = keyValid_q;
    assign key_down  = keyDown_q;
    assign multi     = multi_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix keypad scanner for the cronometer's 4x4 control keypad; it is the input-side counterpart of the multiplexed display driver. It drives one keypad column low at a time, samples the active-low row lines, and debounces across whole scan frames. It reports a single clean key event per press: a 4-bit key code plus a one-cycle valid pulse. Sits between the board pins and the cronometer control FSM.

## Interface

Parameters:
- SCAN_DIV, 17: width of the column settle counter; one column tick every 2^SCAN_DIV clk cycles.
- DEBOUNCE, 3: number of consecutive identical scan frames required to commit a new keypad state (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- row  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk.
- col  output  4  column drive, one-hot active-low.
- key  output  4  code of last committed single key: {col_index[1:0], row_index[1:0]}.
- key_valid  output  1  one-cycle pulse when a new single-key press is committed.
- key_down  output  1  level: committed state has at least one key pressed.
- multi  output  1  level: committed state has two or more keys pressed.

## Operation

- row passes through a 2-FF synchronizer before any use.
- Settle counter (SCAN_DIV bits) free-runs; terminal count = tick.
- On tick: synchronized ~row stored into frame bits [4*ci+3:4*ci], ci = current column index; then col rotates to drive column ci+1 (1110→1101→1011→0111→1110); ci wraps 3→0.
- Tick with ci==3 completes a frame (16-bit pressed map, bit 4*c+r):
  - frame != prev_frame: prev_frame <= frame, stable_cnt <= 1.
  - frame == prev_frame: stable_cnt increments, saturating at DEBOUNCE.
  - Commit when stable_cnt reaches DEBOUNCE (DEBOUNCE==1: commit on every frame change): committed <= frame.
- On commit:
  - key_down <= |frame; multi <= popcount(frame)>=2.
  - If previous committed map was all-zero and new map has exactly one bit set: key <= its code, key_valid pulses.
  - All other transitions (release, single→multi, multi→single, single→different single without release): no pulse, key holds.
- Row change mid-frame yields a mismatching frame → stable_cnt restarts; bounce never produces extra events.

## Timing

- Reset values: col=4'b1110, key=4'h0, key_valid=0, key_down=0, multi=0; counter, ci, stable_cnt, frame, prev_frame, committed all 0.
- Reset is asynchronous on assertion; outputs take reset values immediately, pending debounce discarded.
- Column tick period: 2^SCAN_DIV cycles; frame period: 4*2^SCAN_DIV cycles.
- Row sample taken at end of a full settle period for its column; synchronizer adds 2 cycles of row latency (settle period must exceed 2).
- Commit and outputs update registered: key_valid/key/key_down/multi change one cycle after the frame-completing tick.
- Press latency: DEBOUNCE full stable frames after the first frame containing the press (worst case +1 frame for the press arriving mid-frame).
- key_valid is high for exactly one clk cycle per committed press.

## Structure

- Package keypad_pkg: ROWS=4, COLS=4, KEY_W=4, typedef frame_t (logic [15:0]), functions popcount_ge2(frame_t) and encode_onehot(frame_t) → key code.
- Sub-module sync2: generic 2-FF synchronizer (async active-low reset, reset value 1 for active-low rows), instantiated on row.
- Scanner, frame compare and commit logic stay in keypad_scan.

## Test plan

Bench uses SCAN_DIV=2 (tick every 4 cycles, frame 16 cycles), DEBOUNCE=3; keypad model pulls row[r] low when col[c] low and key (c,r) held.
- Reset held then released → col=1110 during reset, 1101 after first tick, 1110 again after 16 cycles; all other outputs 0.
- Hold key (2,1) → exactly one key_valid with key=4'h9, key_down=1, multi=0 within 4 frames; release → key_down=0 after 3–4 frames, no pulse, key stays 4'h9.
- Key (0,3) bouncing every 5 cycles for 60 cycles then stable → exactly one key_valid, key=4'h3.
- Hold (0,0) and (3,3) together from idle → multi=1, key_down=1, key_valid never asserted; release (3,3) → multi=0, still no pulse.
- Assert rst mid-debounce of key (1,2) → outputs reset immediately; after release with key still held, one key_valid with key=4'h6 after full debounce from scratch.
